simd_sat_accumulator: RTL and testbench
=======================================

Name: simd_sat_accumulator

Overview:
- Sequential stage directly downstream of the packed SIMD saturating adder (`alu`). It accumulates a packet of 32-bit packed words lane-by-lane and emits one reduced word per packet.
- Lane arithmetic matches `alu`: signed two's complement per lane, with wrap or saturate behaviour.
- Valid/ready handshake on both input and output.
- Provides per-lane sticky overflow flags and a beat count, used by downstream status and debug logic.

Parameters:
- MAX_BEATS, 16: maximum beats per packet. The beat that brings the count to MAX_BEATS is treated as last. Legal range 1..255.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  stage can accept a beat.
- in_data  input  32  packed lanes.
- in_width  input  2  lane width: 0 = 4x8-bit, 1 = 2x16-bit, 2 = 1x32-bit, 3 = treated as 2.
- in_saturate  input  1  1 = saturate on overflow, 0 = wrap.
- in_last  input  1  marks the final beat of a packet.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  32  accumulated packed result.
- out_flags  output  4  sticky per-lane overflow flags.
- out_count  output  8  number of beats accepted in the packet.

Behaviour:
- Reset (rst=1 at an edge):
  - state <= IDLE; acc, out_data, out_flags, out_count, latched width and latched saturate <= 0; out_valid <= 0.
  - in_ready = 0 while rst is high. in_ready = 1 in the first cycle after rst deasserts.
  - Reset mid-packet discards all partial state with no output.
- States:
  - IDLE: in_ready = 1, out_valid = 0.
    - On accept: latch in_width and in_saturate; acc <= lane_add(0, in_data); count <= 1.
    - Go to DONE if the beat is last, else go to ACCUM.
  - ACCUM: in_ready = 1.
    - On accept: acc <= lane_add(acc, in_data) using the latched width/saturate; count += 1.
    - in_width and in_saturate are ignored on non-first beats.
    - Go to DONE if the beat is last.
  - DONE: in_ready = 0, out_valid = 1.
    - out_data, out_flags and out_count are stable until the handshake.
    - On out_valid && out_ready: clear acc, flags and count; go to IDLE. in_ready = 1 the next cycle, so there is one bubble per packet.
- "Last" = in_last || (count + 1 == MAX_BEATS).
- Latency: out_valid rises the cycle after the last beat is accepted.
- No accept when in_valid = 0; state holds.
- lane_add, per lane:
  - Compute the signed sum of acc lane and input lane.
  - Overflow occurs when the operand signs are equal and the sum sign differs.
  - On overflow with saturate = 1: the result is max positive (0x7F / 0x7FFF / 0x7FFFFFFF) if the operands are positive, else min negative (0x80 / 0x8000 / 0x80000000).
  - On overflow with saturate = 0: the result is the wrapped sum.
  - No carry propagates across lane boundaries.
- Flag mapping (a flag sets on overflow whether or not saturate is set; flags are sticky until the packet is consumed):
  - width 0: bit i = byte lane i.
  - width 1: bit0 = lane [15:0], bit1 = lane [31:16], bits 3:2 = 0.
  - width 2/3: bit0 only.

Optional Feature:
- Macro: SIMD_ACC_CLEAR_EN.
- When defined: adds input port acc_clear (1 bit).
  - acc_clear = 1 at an edge aborts any packet in IDLE, ACCUM or DONE. State returns to IDLE; acc, flags, count and out_valid are cleared; any beat presented in that cycle is dropped.
  - acc_clear has priority below rst and above all handshakes.
- When undefined: the port does not exist, and behaviour is exactly as above.

Test Plan:
1. Wrapping 32-bit: width=2, saturate=0, beats 0x7FFFFFFF then 0x00000001 (last). Expect out_data=0x80000000, out_flags=0001, out_count=2.
2. Saturating 32-bit: width=2, saturate=1, beats 0x7FFFFFFF then 0x00000913 (last). Expect out_data=0x7FFFFFFF, out_flags=0001.
3. Saturating 16-bit with latched width: width=1, saturate=1, beats 0x00047FFF then 0x000104BC (last, with in_width=0 on that beat). Expect out_data=0x00057FFF, out_flags=0001, since the width latched on the first beat applies.
4. Saturating 8-bit: width=0, saturate=1, beats 0x8001017F then 0xFF01017F (last). Expect out_data=0x8002027F, out_flags=1001.
5. Forced termination and backpressure: MAX_BEATS=4, four beats of 0x01010101 with in_last=0, out_ready held 0 for 3 cycles.
   - out_valid rises the cycle after beat 4, with out_data=0x04040404 and out_count=4.
   - Outputs stay stable and in_ready stays 0 until out_ready is asserted.
   - in_ready returns to 1 the next cycle.
6. Reset mid-packet: rst=1 for 1 cycle in ACCUM after 2 beats. All outputs read 0, no out_valid appears, and the next packet 0x00000005 (last) yields out_data=0x00000005 with out_count=1.

Source files
------------

// File: rtl/simd_sat_accumulator.sv
// rtl/simd_sat_accumulator.sv - packed SIMD saturating accumulator with per-lane sticky overflow flags
//
// Accumulates a packet of 32-bit packed words lane-by-lane and emits one
// reduced word, sticky per-lane overflow flags and the beat count per packet.
// Optional macro SIMD_ACC_CLEAR_EN adds the acc_clear abort input.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   acc_clear                (SIMD_ACC_CLEAR_EN only) abort current packet
//   in_valid/in_ready        input beat handshake
//   in_data                  packed lanes
//   in_width                 0 = 4x8, 1 = 2x16, 2/3 = 1x32 (latched on first beat)
//   in_saturate              1 = saturate, 0 = wrap (latched on first beat)
//   in_last                  final beat of a packet
//   out_valid/out_ready      result handshake
//   out_data                 accumulated packed result
//   out_flags                sticky per-lane overflow flags
//   out_count                beats accepted in the packet
module simd_sat_accumulator #(
  parameter int unsigned MAX_BEATS = 16
) (
  input  logic        clk,
  input  logic        rst,
`ifdef SIMD_ACC_CLEAR_EN
  input  logic        acc_clear,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_width,
  input  logic        in_saturate,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_flags,
  output logic [7:0]  out_count
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc;
  logic [3:0]  flags;
  logic [7:0]  count;
  logic [1:0]  lat_w;
  logic        lat_sat;

  logic        accept;
  logic        last;
  logic [8:0]  cnt_next;
  logic [31:0] add_a;
  logic [1:0]  add_w;
  logic        add_sat;
  logic [35:0] add_out;

  // Returns {overflow_flags[3:0], sum[31:0]}. Overflow is detected from the
  // sign rule: equal operand signs and a differing sum sign.
  function automatic logic [35:0] lane_add(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] w, input logic sat);
    logic [31:0] r;
    logic [3:0]  f;
    logic [7:0]  s8;
    logic [15:0] s16;
    logic [31:0] s32;
    r = '0;
    f = '0;
    case (w)
      2'd0: begin
        for (int i = 0; i < 4; i++) begin
          s8 = a[8*i +: 8] + b[8*i +: 8];
          r[8*i +: 8] = s8;
          if (a[8*i+7] == b[8*i+7] && s8[7] != a[8*i+7]) begin
            f[i] = 1'b1;
            if (sat) r[8*i +: 8] = a[8*i+7] ? 8'h80 : 8'h7F;
          end
        end
      end
      2'd1: begin
        for (int i = 0; i < 2; i++) begin
          s16 = a[16*i +: 16] + b[16*i +: 16];
          r[16*i +: 16] = s16;
          if (a[16*i+15] == b[16*i+15] && s16[15] != a[16*i+15]) begin
            f[i] = 1'b1;
            if (sat) r[16*i +: 16] = a[16*i+15] ? 16'h8000 : 16'h7FFF;
          end
        end
      end
      default: begin
        s32 = a + b;
        r = s32;
        if (a[31] == b[31] && s32[31] != a[31]) begin
          f[0] = 1'b1;
          if (sat) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
      end
    endcase
    return {f, r};
  endfunction

  // The first beat of a packet adds onto zero using its own width/saturate;
  // later beats use the values latched from that first beat.
  assign add_a   = (state_q == IDLE) ? 32'd0 : acc;
  assign add_w   = (state_q == IDLE) ? in_width : lat_w;
  assign add_sat = (state_q == IDLE) ? in_saturate : lat_sat;
  assign add_out = lane_add(add_a, in_data, add_w, add_sat);

  assign accept   = in_valid && in_ready;
  assign cnt_next = {1'b0, count} + 9'd1;
  assign last     = in_last || (cnt_next == 9'(MAX_BEATS));

  assign out_data  = acc;
  assign out_flags = flags;
  assign out_count = count;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (accept) state_d = last ? DONE : ACCUM;
      end
      ACCUM: begin
        in_ready = !rst;
        if (accept && last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
`ifdef SIMD_ACC_CLEAR_EN
    end else if (acc_clear) begin
      state_q <= IDLE;
`endif
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      flags   <= '0;
      count   <= '0;
      lat_w   <= '0;
      lat_sat <= 1'b0;
`ifdef SIMD_ACC_CLEAR_EN
    end else if (acc_clear) begin
      acc   <= '0;
      flags <= '0;
      count <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            lat_w   <= in_width;
            lat_sat <= in_saturate;
            acc     <= add_out[31:0];
            flags   <= add_out[35:32];
            count   <= 8'd1;
          end
        end
        ACCUM: begin
          if (accept) begin
            acc   <= add_out[31:0];
            flags <= flags | add_out[35:32];
            count <= cnt_next[7:0];
          end
        end
        DONE: begin
          if (out_ready) begin
            acc   <= '0;
            flags <= '0;
            count <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_simd_sat_accumulator.sv
// tb/tb_simd_sat_accumulator.sv - self-checking bench for simd_sat_accumulator
module tb_simd_sat_accumulator;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst;
`ifdef SIMD_ACC_CLEAR_EN
  logic        acc_clear = 1'b0;
`endif
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_width;
  logic        in_saturate;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_flags;
  logic [7:0]  out_count;

  simd_sat_accumulator #(.MAX_BEATS(MAXB)) dut (
    .clk(clk),
    .rst(rst),
`ifdef SIMD_ACC_CLEAR_EN
    .acc_clear(acc_clear),
`endif
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_width(in_width),
    .in_saturate(in_saturate),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_flags(out_flags),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    logic [3:0]  f;
    logic [7:0]  c;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] last_data;
  logic [3:0]  last_flags;
  logic [7:0]  last_count;

  logic [31:0] m_acc;
  logic [3:0]  m_flags;
  int          m_count;
  int          m_w;
  bit          m_sat;

  // Per-lane signed integer arithmetic: range-check the true sum.
  function automatic logic [35:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                            input int w, input bit sat);
    int lanes, bits;
    longint half, mask, sa, sb, s;
    logic [31:0] r, tmp;
    logic [3:0] f;
    lanes = (w == 0) ? 4 : (w == 1) ? 2 : 1;
    bits  = 32 / lanes;
    half  = longint'(1) << (bits - 1);
    mask  = (half << 1) - 1;
    r = '0;
    f = '0;
    for (int i = 0; i < lanes; i++) begin
      sa = (longint'(a) >> (i * bits)) & mask;
      if (sa >= half) sa = sa - 2 * half;
      sb = (longint'(b) >> (i * bits)) & mask;
      if (sb >= half) sb = sb - 2 * half;
      s = sa + sb;
      if (s > half - 1 || s < -half) begin
        f[i] = 1'b1;
        if (sat) s = (s > 0) ? half - 1 : -half;
      end
      tmp = 32'(s & mask);
      r = r | (tmp << (i * bits));
    end
    return {f, r};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  // Cycle compare: handshake signals every cycle, result fields while valid.
  always @(negedge clk) begin
    checks++;
    if (in_ready !== (!rst && q.size() == 0)) begin
      errors++;
      $display("FAIL in_ready got %b exp %b", in_ready, (!rst && q.size() == 0));
    end
    if (!rst) begin
      checks++;
      if (out_valid !== (q.size() != 0)) begin
        errors++;
        $display("FAIL out_valid got %b exp %b", out_valid, (q.size() != 0));
      end
      if (out_valid === 1'b1 && q.size() != 0) begin
        checks++;
        if (out_data !== q[0].d || out_flags !== q[0].f || out_count !== q[0].c) begin
          errors++;
          $display("FAIL result got %h/%b/%0d exp %h/%b/%0d",
                   out_data, out_flags, out_count, q[0].d, q[0].f, q[0].c);
        end
        if (out_ready === 1'b1) begin
          last_data  = out_data;
          last_flags = out_flags;
          last_count = out_count;
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic beat(input logic [31:0] d, input logic [1:0] w, input bit s, input bit lst);
    bit rdy;
    int n;
    logic [35:0] r;
    in_valid = 1'b1; in_data = d; in_width = w; in_saturate = s; in_last = lst;
    rdy = 1'b0;
    n = 0;
    while (!rdy && n < 20) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got 0 exp 1");
      return;
    end
    if (m_count == 0) begin
      m_w = (w == 2'd3) ? 2 : int'(w);
      m_sat = s;
      m_acc = '0;
      m_flags = '0;
    end
    r = model_add(m_acc, d, m_w, m_sat);
    m_acc = r[31:0];
    m_flags = m_flags | r[35:32];
    m_count++;
    if (lst || m_count == MAXB) begin
      q.push_back('{m_acc, m_flags, 8'(m_count)});
      m_count = 0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d exp 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_width = '0;
    in_saturate = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    m_count = 0; m_acc = '0; m_flags = '0; m_w = 0; m_sat = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_flags", 32'(out_flags), 32'd0);
    chk("reset_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;

    // 1: wrapping 32-bit
    beat(32'h7FFF_FFFF, 2'd2, 1'b0, 1'b0);
    beat(32'h0000_0001, 2'd2, 1'b0, 1'b1);
    drain();
    chk("t1_data", last_data, 32'h8000_0000);
    chk("t1_flags", 32'(last_flags), 32'h1);
    chk("t1_count", 32'(last_count), 32'd2);

    // 2: saturating 32-bit
    beat(32'h7FFF_FFFF, 2'd2, 1'b1, 1'b0);
    beat(32'h0000_0913, 2'd2, 1'b1, 1'b1);
    drain();
    chk("t2_data", last_data, 32'h7FFF_FFFF);
    chk("t2_flags", 32'(last_flags), 32'h1);

    // 3: saturating 16-bit, width on second beat ignored
    beat(32'h0004_7FFF, 2'd1, 1'b1, 1'b0);
    beat(32'h0001_04BC, 2'd0, 1'b0, 1'b1);
    drain();
    chk("t3_data", last_data, 32'h0005_7FFF);
    chk("t3_flags", 32'(last_flags), 32'h1);

    // 4: saturating 8-bit, both directions
    beat(32'h8001_017F, 2'd0, 1'b1, 1'b0);
    beat(32'hFF01_017F, 2'd0, 1'b1, 1'b1);
    drain();
    chk("t4_data", last_data, 32'h8002_027F);
    chk("t4_flags", 32'(last_flags), 32'b1001);

    // 5: forced last at MAX_BEATS, backpressure for 3 cycles
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(32'h0101_0101, 2'd0, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_hold_valid", 32'(out_valid), 32'd1);
      chk("t5_hold_data", out_data, 32'h0404_0404);
      chk("t5_hold_count", 32'(out_count), 32'd4);
      chk("t5_hold_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();
    @(negedge clk);
    chk("t5_in_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    // 6: reset mid-packet
    beat(32'h0000_0011, 2'd2, 1'b0, 1'b0);
    beat(32'h0000_0022, 2'd2, 1'b0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_count = 0;
    @(negedge clk);
    chk("t6_out_valid", 32'(out_valid), 32'd0);
    chk("t6_out_data", out_data, 32'd0);
    chk("t6_out_flags", 32'(out_flags), 32'd0);
    chk("t6_out_count", 32'(out_count), 32'd0);
    @(posedge clk); #1;
    beat(32'h0000_0005, 2'd2, 1'b0, 1'b1);
    drain();
    chk("t6_data", last_data, 32'h0000_0005);
    chk("t6_count", 32'(last_count), 32'd1);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
